// File: rtl/mult_pkg.sv
// Shared constants for the iterative radix-4 Booth multiplier controller.
package mult_pkg;

  localparam logic [1:0] MUL_IDLE = 2'd0;
  localparam logic [1:0] MUL_BUSY = 2'd1;
  localparam logic [1:0] MUL_DONE = 2'd2;

  localparam int unsigned MUL_XLEN = 32;
  localparam int unsigned MUL_PW   = 68;
  localparam int unsigned MUL_ITER = 17;

endpackage

// File: rtl/booth.sv
// Radix-4 Booth partial-product cell: digit y selects 0, +-X or +-2X; negatives
// are returned as ~mag with carry-in c = 1 so the caller's adder completes the two's complement.
module booth
  import mult_pkg::*;
#(
  parameter int unsigned PW = MUL_PW
) (
  input  logic [2:0]    y,
  input  logic [PW-1:0] X,
  output logic [PW-1:0] P,
  output logic          c
);

  logic [PW-1:0] mag;
  logic          neg;

  always_comb begin
    mag = '0;
    neg = 1'b0;
    case (y)
      3'b001, 3'b010: mag = X;
      3'b011:         mag = {X[PW-2:0], 1'b0};
      3'b100: begin
        mag = {X[PW-2:0], 1'b0};
        neg = 1'b1;
      end
      3'b101, 3'b110: begin
        mag = X;
        neg = 1'b1;
      end
      default: ;
    endcase
    P = neg ? ~mag : mag;
    c = neg;
  end

endmodule

// File: rtl/mult_booth_ctrl.sv
// Iterative 32x32 MULT/MULTU controller: one radix-4 Booth digit per cycle into a 68-bit
// accumulator. Optional early termination is enabled by MULT_BOOTH_EARLY_TERM_EN.
module mult_booth_ctrl
  import mult_pkg::*;
#(
  parameter int unsigned XLEN = MUL_XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            mul_valid,
  output logic            mul_ready,
  input  logic            mul_signed,
  input  logic [XLEN-1:0] mul_a,
  input  logic [XLEN-1:0] mul_b,
  input  logic            cancel,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [XLEN-1:0] res_hi,
  output logic [XLEN-1:0] res_lo,
  output logic            busy
);

  localparam int unsigned MW   = XLEN + 2;
  localparam int unsigned YW   = MW + 1;
  localparam int unsigned PW   = 2 * XLEN + 4;
  localparam int unsigned ITER = MW / 2;
  localparam int unsigned CW   = $clog2(ITER);

  logic [1:0]    state;
  logic [PW-1:0] acc, xreg, pp, acc_next;
  logic [YW-1:0] yreg, yreg_next;
  logic [CW-1:0] cnt;
  logic          pc, last;
  logic [MW-1:0] xe, ye;

  assign xe = {{2{mul_signed & mul_a[XLEN-1]}}, mul_a};
  assign ye = {{2{mul_signed & mul_b[XLEN-1]}}, mul_b};

  booth #(.PW(PW)) u_booth (
    .y (yreg[2:0]),
    .X (xreg),
    .P (pp),
    .c (pc)
  );

  assign acc_next  = acc + pp + {{(PW-1){1'b0}}, pc};
  assign yreg_next = {{2{yreg[YW-1]}}, yreg[YW-1:2]};

`ifdef MULT_BOOTH_EARLY_TERM_EN
  // A fully sign-filled remainder encodes only zero digits, so acc is already final.
  assign last = (cnt == CW'(ITER - 1)) || (yreg_next == '0) || (yreg_next == '1);
`else
  assign last = (cnt == CW'(ITER - 1));
`endif

  assign mul_ready = (state == MUL_IDLE);
  assign res_valid = (state == MUL_DONE);
  assign busy      = (state == MUL_BUSY);

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= MUL_IDLE;
      acc    <= '0;
      xreg   <= '0;
      yreg   <= '0;
      cnt    <= '0;
      res_hi <= '0;
      res_lo <= '0;
    end else begin
      case (state)
        MUL_IDLE: begin
          if (mul_valid && !cancel) begin
            state <= MUL_BUSY;
            xreg  <= {{(PW-MW){xe[MW-1]}}, xe};
            yreg  <= {ye, 1'b0};
            acc   <= '0;
            cnt   <= '0;
          end
        end
        MUL_BUSY: begin
          if (cancel) begin
            state <= MUL_IDLE;
          end else begin
            acc  <= acc_next;
            xreg <= {xreg[PW-3:0], 2'b00};
            yreg <= yreg_next;
            cnt  <= cnt + CW'(1);
            if (last) begin
              state  <= MUL_DONE;
              res_hi <= acc_next[2*XLEN-1:XLEN];
              res_lo <= acc_next[XLEN-1:0];
            end
          end
        end
        MUL_DONE: begin
          if (cancel || res_ready)
            state <= MUL_IDLE;
        end
        default: state <= MUL_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_booth_ctrl.sv
// Directed bench for mult_booth_ctrl: vector table plus backpressure, cancel and reset sequences.
module tb_mult_booth_ctrl;

  logic        clk, reset;
  logic        mul_valid, mul_ready, mul_signed;
  logic [31:0] mul_a, mul_b;
  logic        cancel, res_valid, res_ready, busy;
  logic [31:0] res_hi, res_lo;

  int tests = 0;
  int fails = 0;

  mult_booth_ctrl #(.XLEN(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .mul_valid  (mul_valid),
    .mul_ready  (mul_ready),
    .mul_signed (mul_signed),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .cancel     (cancel),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_hi     (res_hi),
    .res_lo     (res_lo),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 50 && !mul_ready; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Accept on the next edge, then count edges until res_valid is seen.
  task automatic do_mul(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        output int lat);
    wait_idle();
    mul_signed = sgn;
    mul_a      = a;
    mul_b      = b;
    mul_valid  = 1'b1;
    @(posedge clk);
    #1;
    mul_valid = 1'b0;
    lat = 1;
    while (!res_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("res_valid_seen", 64'(res_valid), 64'd1);
  endtask

  task automatic take();
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    chk("ready_after_take", {62'd0, mul_ready, res_valid}, 64'd2);
  endtask

  int lat;
  int pulses;
  logic [63:0] held;

  initial begin
    vecs[0]  = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    vecs[1]  = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[2]  = '{1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[3]  = '{1'b1, 32'h80000000, 32'h00000001, 32'hFFFFFFFF, 32'h80000000};
    vecs[4]  = '{1'b1, 32'h00000007, 32'h00000006, 32'h00000000, 32'h0000002A};
    vecs[5]  = '{1'b0, 32'h80000000, 32'h00000002, 32'h00000001, 32'h00000000};
    vecs[6]  = '{1'b1, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA};
    vecs[7]  = '{1'b0, 32'hFFFFFFFE, 32'h00000003, 32'h00000002, 32'hFFFFFFFA};
    vecs[8]  = '{1'b1, 32'h12345678, 32'h00000000, 32'h00000000, 32'h00000000};
    vecs[9]  = '{1'b1, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001};
    vecs[10] = '{1'b0, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
    vecs[11] = '{1'b1, 32'hFFFF0000, 32'h0000FFFF, 32'hFFFFFFFF, 32'h00010000};

    reset = 1'b1; mul_valid = 1'b0; mul_signed = 1'b0; mul_a = '0; mul_b = '0;
    cancel = 1'b0; res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset_ctl", {61'd0, mul_ready, res_valid, busy}, 64'd4);
    chk("reset_res", {res_hi, res_lo}, 64'd0);

    for (int i = 0; i < 12; i++) begin
      do_mul(vecs[i].sgn, vecs[i].a, vecs[i].b, lat);
`ifndef MULT_BOOTH_EARLY_TERM_EN
      chk($sformatf("lat_%0d", i), 64'(lat), 64'd18);
`endif
      chk($sformatf("prod_%0d", i), {res_hi, res_lo}, {vecs[i].hi, vecs[i].lo});
      take();
    end

    // Backpressure: result held, new requests ignored.
    do_mul(1'b1, 32'd3, 32'd5, lat);
    held = {res_hi, res_lo};
    chk("bp_first", held, 64'd15);
    mul_valid = 1'b1; mul_a = 32'd9; mul_b = 32'd9;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("bp_ctl_%0d", i), {61'd0, res_valid, mul_ready, busy}, 64'd4);
      chk($sformatf("bp_hold_%0d", i), {res_hi, res_lo}, held);
    end
    mul_valid = 1'b0;
    take();

    // Cancel at BUSY cycle 7, then confirm no result ever appears.
    wait_idle();
    mul_signed = 1'b1; mul_a = 32'd11; mul_b = 32'h55555555; mul_valid = 1'b1;
    @(posedge clk);
    #1;
    mul_valid = 1'b0;
    chk("busy_started", 64'(busy), 64'd1);
    repeat (7) @(posedge clk);
    #1;
    cancel = 1'b1;
    @(posedge clk);
    #1;
    cancel = 1'b0;
    chk("cancel_busy", {61'd0, mul_ready, res_valid, busy}, 64'd4);
    pulses = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk);
      #1;
      if (res_valid || busy) pulses++;
    end
    chk("cancel_no_result", 64'(pulses), 64'd0);

    cancel = 1'b1; mul_valid = 1'b1;
    @(posedge clk);
    #1;
    cancel = 1'b0; mul_valid = 1'b0;
    chk("cancel_idle", {61'd0, mul_ready, res_valid, busy}, 64'd4);

    // Cancel beats res_ready in DONE.
    do_mul(1'b0, 32'd100, 32'd100, lat);
    chk("done_prod", {res_hi, res_lo}, 64'd10000);
    cancel = 1'b1; res_ready = 1'b1;
    @(posedge clk);
    #1;
    cancel = 1'b0; res_ready = 1'b0;
    chk("cancel_done", {61'd0, mul_ready, res_valid, busy}, 64'd4);

    // Reset mid-operation, then a clean 7 x 6.
    wait_idle();
    mul_signed = 1'b1; mul_a = 32'd123; mul_b = 32'h01234567; mul_valid = 1'b1;
    @(posedge clk);
    #1;
    mul_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset_busy_ctl", {61'd0, mul_ready, res_valid, busy}, 64'd4);
    chk("reset_busy_res", {res_hi, res_lo}, 64'd0);
    do_mul(1'b1, 32'd7, 32'd6, lat);
`ifdef MULT_BOOTH_EARLY_TERM_EN
    chk("lat_7x6", 64'(lat), 64'd3);
`else
    chk("lat_7x6", 64'(lat), 64'd18);
`endif
    chk("prod_7x6", {res_hi, res_lo}, 64'd42);
    take();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
